pipe_fft_dly_ctrl: RTL

PIPE_FFT_DLY_CTRL -- requirements
Module: pipe_fft_dly_ctrl

---
 rtl/pipe_fft_pkg.sv | 18 +
 rtl/pipe_fft_dly_fill.sv | 40 ++++
 rtl/pipe_fft_dly_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_fft_pkg.sv
// Shared defaults and address-width helper for the pipelined FFT delay-line blocks.
package pipe_fft_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int WIDTH_DEF = 68;
    localparam int DLY_DEF   = 63;

    // Smallest r with 2**r >= n; used for RAM address and fill-counter widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_fft_dly_fill.sv
// Fill counter for the delay line: counts accepted samples, saturates at DLY, primed is combinational.
// Optional o_fill port exists only when PIPE_FFT_DLY_FILL_EN is defined; flush clears on the next edge.
module pipe_fft_dly_fill
    import pipe_fft_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DLY   = DLY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_accept,
`ifdef PIPE_FFT_DLY_FILL_EN
    output logic [clog2(DEPTH)-1:0] o_fill,
`endif
    output logic                    o_primed
);

    localparam int            AW    = clog2(DEPTH);
    localparam logic [AW-1:0] DLY_A = AW'(DLY);

    logic [AW-1:0] r_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (i_flush) begin
            r_fill <= '0;
        end else if (i_accept && (r_fill != DLY_A)) begin
            r_fill <= r_fill + AW'(1);
        end
    end

    assign o_primed = (r_fill == DLY_A);

`ifdef PIPE_FFT_DLY_FILL_EN
    assign o_fill = r_fill;
`endif

endmodule

// File: rtl/pipe_fft_dly_ctrl.sv
// Sample-driven delay-line controller for an external 1-cycle-latency RAM; output lags the read by 1 cycle.
// No backpressure: gaps in dInValid stall the line. PIPE_FFT_DLY_FILL_EN adds fill/primed ports.
module pipe_fft_dly_ctrl
    import pipe_fft_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DLY   = DLY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        dIn,
    input  logic                    dInValid,
    output logic [WIDTH-1:0]        dOut,
    output logic                    dOutValid,
    output logic [clog2(DEPTH)-1:0] wAddr,
    output logic [WIDTH-1:0]        wD,
    output logic                    wEn,
    output logic [clog2(DEPTH)-1:0] rAddr,
    input  logic [WIDTH-1:0]        rD
`ifdef PIPE_FFT_DLY_FILL_EN
    ,
    output logic [clog2(DEPTH)-1:0] fill,
    output logic                    primed
`endif
);

    localparam int            AW    = clog2(DEPTH);
    localparam logic [AW-1:0] DLY_A = AW'(DLY);

    logic          w_wen;
    logic          w_primed;
    logic          w_issue;
    logic [AW-1:0] r_wptr;
    logic          r_rd_vld;

    assign w_wen   = dInValid & ~flush;
    assign w_issue = w_wen & w_primed;

    assign wD    = dIn;
    assign wEn   = w_wen;
    assign wAddr = r_wptr;
    // DLY <= DEPTH-1 keeps the read address distinct from the write address.
    assign rAddr = r_wptr - DLY_A;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
        end else if (w_wen) begin
            r_wptr <= r_wptr + AW'(1);
        end
    end

    // w_wen already excludes flush, so a flush cycle never issues a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
        end
    end

    assign dOutValid = r_rd_vld;
    assign dOut      = rD;

    pipe_fft_dly_fill #(
        .DEPTH (DEPTH),
        .DLY   (DLY)
    ) u_fill (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_accept (w_wen),
`ifdef PIPE_FFT_DLY_FILL_EN
        .o_fill   (fill),
`endif
        .o_primed (w_primed)
    );

`ifdef PIPE_FFT_DLY_FILL_EN
    assign primed = w_primed;
`endif

endmodule
